toy_bus_ack_dec_node_2out: RTL and testbench
============================================

Name: toy_bus_ack_dec_node_2out

Overview:
- Splits one ToyBusAck stream (dmem payload, ack direction) onto two downstream ports, selected by tgt_id.
- Each output has its own small FIFO, so a stalled target does not block acks for the other target once that beat is accepted.
- Together with the 2:1 age-matrix arbitration node, it completes the merge/split pair on the ack network.
- Beats with an unknown tgt_id are consumed, dropped and reported.

Parameters:
- OUT0_TGT_ID, 4'd0, tgt_id value routed to out0.
- OUT1_TGT_ID, 4'd1, tgt_id value routed to out1; must differ from OUT0_TGT_ID.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in0_vld  input  1  upstream beat valid
- in0_rdy  output  1  upstream beat accepted when vld&&rdy
- in0_opcode  input  1  ack opcode
- in0_data  input  256  ack data
- in0_sideband  input  32  sideband
- in0_src_id  input  4  source id
- in0_tgt_id  input  4  target id; selects the output
- outN_vld  output  1  (N=0,1) downstream valid
- outN_rdy  input  1  downstream ready
- outN_opcode / outN_data / outN_sideband / outN_src_id / outN_tgt_id  output  1/256/32/4/4  payload, passed unmodified
- err_unroutable  output  1  sticky; set on the first dropped beat
- drop_cnt  output  DROP_CNT_W  saturating count of dropped beats

Behaviour:
- Interface fact: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: outN_vld=0; all out payload=0; in0_rdy=1; err_unroutable=0; drop_cnt=0; FIFO pointers and counts=0. FIFO storage is not reset.
- Routing, combinational on in0_tgt_id:
  - sel0 = (tgt_id==OUT0_TGT_ID).
  - sel1 = (tgt_id==OUT1_TGT_ID).
  - drop = ~sel0 & ~sel1.
- in0_rdy:
  - (sel0 & ~full0) | (sel1 & ~full1) | drop.
  - fullN is a registered FIFO state. There is no combinational path from outN_rdy to in0_rdy.
  - A pop in the same cycle does not free space for a push into a full FIFO that cycle.
- Upstream rule: while in0_vld=1 and in0_rdy=0, upstream holds the payload (including tgt_id) stable. The node makes no assumption about in0_vld being held.
- Push: in0_vld & in0_rdy & selN writes the full payload into FIFO N at its write pointer.
- Latency: a beat accepted in cycle t is visible on outN in cycle t+1 if FIFO N was empty. Throughput is 1 beat/cycle per output.
- Output side:
  - outN_vld = (countN != 0).
  - Payload is the head entry. Payload outputs are forced to 0 while outN_vld=0.
  - Pop on outN_vld & outN_rdy.
  - Once outN_vld is asserted, it and the payload stay stable until popped.
- Simultaneous push and pop on the same FIFO: countN is unchanged and both pointers advance. Legal at any non-full count, including count 1 (head moves to the new entry next cycle).
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full = (count==DEPTH), empty = (count==0); count is log2(DEPTH)+1 bits.
- Ordering: beats to the same output leave in acceptance order. No ordering guarantee exists between out0 and out1.
- Drop handling:
  - An accepted beat with drop=1 is discarded.
  - drop_cnt increments by 1 and saturates at all-ones.
  - err_unroutable sets and stays set until reset.
- Reset mid-operation: FIFO contents are lost and outputs return to reset values asynchronously. Upstream must not expect replay.

Decomposition:
- Shared package toy_bus_ack_pkg:
  - widths: ACK_OPCODE_W=1, ACK_DATA_W=256, ACK_SB_W=32, ID_W=4.
  - payload width constant = 297.
  - packed ToyBusAck payload typedef.
- One sub-module, toy_bus_ack_fifo:
  - parameters: DEPTH, payload width.
  - ports: push_vld/full/push_pld, pop_vld/pop_rdy/pop_pld.
  - instantiated twice.
- Top level holds routing, in0_rdy, payload gating and drop logic.

Test Plan:
- Single beat, tgt_id=0, data=0xA5.., out0_rdy=1 → out0_vld=1 the next cycle with identical payload; out1_vld stays 0; drop_cnt=0.
- Back-to-back: 4 beats alternating tgt_id 0/1, both outputs ready → in0_rdy stays 1; each output emits its 2 beats in order, 1 cycle after acceptance.
- Backpressure: out0_rdy=0, 3 beats to tgt 0 → first 2 accepted; in0_rdy=0 on the 3rd until out0_rdy=1 pops. Meanwhile a beat to tgt 1 at in0 is accepted immediately.
- Simultaneous push/pop at count=1 across 16 cycles → count stays 1, pointers wrap, data order preserved (check with a scoreboard).
- Unroutable: tgt_id=7, held 300 beats → in0_rdy=1, nothing on either output, err_unroutable=1 after the first beat, drop_cnt=255 (saturated).
- Reset asserted with both FIFOs full → outN_vld=0 and payload=0 immediately; after release, a fresh beat routes correctly with 1-cycle latency.

Source files
------------

// File: rtl/toy_bus_ack_pkg.sv
// Shared definitions for the ToyBusAck (dmem ack direction) network.
package toy_bus_ack_pkg;

    localparam int unsigned ACK_OPCODE_W = 1;
    localparam int unsigned ACK_DATA_W   = 256;
    localparam int unsigned ACK_SB_W     = 32;
    localparam int unsigned ID_W         = 4;

    // Total packed payload width: opcode + data + sideband + src_id + tgt_id.
    localparam int unsigned ACK_PLD_W    = ACK_OPCODE_W + ACK_DATA_W + ACK_SB_W + 2 * ID_W;

    // One ack beat, MSB first in this field order.
    typedef struct packed {
        logic [ACK_OPCODE_W-1:0] opcode;
        logic [ACK_DATA_W-1:0]   data;
        logic [ACK_SB_W-1:0]     sideband;
        logic [ID_W-1:0]         src_id;
        logic [ID_W-1:0]         tgt_id;
    } ack_pld_t;

    // Zero the payload whenever its valid is low, so idle ports present all-zero.
    function automatic ack_pld_t gate_pld(input logic vld, input ack_pld_t pld);
        gate_pld = vld ? pld : '0;
    endfunction

endpackage

// File: rtl/toy_bus_ack_fifo.sv
// Small synchronous FIFO used per output of the ack split node.
// Full is purely registered state: a pop never frees space for a push in the same cycle.
module toy_bus_ack_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PLD_W = 297
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    output logic             full,
    input  logic [PLD_W-1:0] push_pld,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [PLD_W-1:0] pop_pld
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [PLD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Handshake qualification and status flags.
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        pop_vld = (count != '0);
        push    = push_vld & ~full;
        pop     = pop_vld & pop_rdy;
        pop_pld = mem[rd_ptr];
    end

    // Storage is written on push only; it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_pld;
        end
    end

    // Pointers wrap naturally; count is unchanged on simultaneous push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/toy_bus_ack_dec_node_2out.sv
// 1:2 split node for the ToyBusAck network: routes each beat to out0/out1 by
// tgt_id through a per-output FIFO; unknown targets are consumed and counted.
module toy_bus_ack_dec_node_2out
    import toy_bus_ack_pkg::*;
#(
    parameter logic [ID_W-1:0] OUT0_TGT_ID = 4'd0,
    parameter logic [ID_W-1:0] OUT1_TGT_ID = 4'd1,
    parameter int unsigned     DEPTH       = 2,
    parameter int unsigned     DROP_CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    in0_vld,
    output logic                    in0_rdy,
    input  logic [ACK_OPCODE_W-1:0] in0_opcode,
    input  logic [ACK_DATA_W-1:0]   in0_data,
    input  logic [ACK_SB_W-1:0]     in0_sideband,
    input  logic [ID_W-1:0]         in0_src_id,
    input  logic [ID_W-1:0]         in0_tgt_id,

    output logic                    out0_vld,
    input  logic                    out0_rdy,
    output logic [ACK_OPCODE_W-1:0] out0_opcode,
    output logic [ACK_DATA_W-1:0]   out0_data,
    output logic [ACK_SB_W-1:0]     out0_sideband,
    output logic [ID_W-1:0]         out0_src_id,
    output logic [ID_W-1:0]         out0_tgt_id,

    output logic                    out1_vld,
    input  logic                    out1_rdy,
    output logic [ACK_OPCODE_W-1:0] out1_opcode,
    output logic [ACK_DATA_W-1:0]   out1_data,
    output logic [ACK_SB_W-1:0]     out1_sideband,
    output logic [ID_W-1:0]         out1_src_id,
    output logic [ID_W-1:0]         out1_tgt_id,

    output logic                    err_unroutable,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    ack_pld_t in_pld;
    ack_pld_t head0;
    ack_pld_t head1;
    ack_pld_t out0_pld;
    ack_pld_t out1_pld;

    logic sel0;
    logic sel1;
    logic drop;
    logic full0;
    logic full1;
    logic push0;
    logic push1;
    logic drop_acc;

    // Assemble the inbound beat and decode its destination.
    always_comb begin
        in_pld.opcode   = in0_opcode;
        in_pld.data     = in0_data;
        in_pld.sideband = in0_sideband;
        in_pld.src_id   = in0_src_id;
        in_pld.tgt_id   = in0_tgt_id;

        sel0 = (in0_tgt_id == OUT0_TGT_ID);
        sel1 = (in0_tgt_id == OUT1_TGT_ID);
        drop = ~sel0 & ~sel1;
    end

    // Ready depends only on registered full flags, never on downstream ready.
    always_comb begin
        in0_rdy  = (sel0 & ~full0) | (sel1 & ~full1) | drop;
        push0    = in0_vld & in0_rdy & sel0;
        push1    = in0_vld & in0_rdy & sel1;
        drop_acc = in0_vld & in0_rdy & drop;
    end

    toy_bus_ack_fifo #(
        .DEPTH (DEPTH),
        .PLD_W (ACK_PLD_W)
    ) u_fifo0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push0),
        .full     (full0),
        .push_pld (in_pld),
        .pop_vld  (out0_vld),
        .pop_rdy  (out0_rdy),
        .pop_pld  (head0)
    );

    toy_bus_ack_fifo #(
        .DEPTH (DEPTH),
        .PLD_W (ACK_PLD_W)
    ) u_fifo1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push1),
        .full     (full1),
        .push_pld (in_pld),
        .pop_vld  (out1_vld),
        .pop_rdy  (out1_rdy),
        .pop_pld  (head1)
    );

    // Present the FIFO heads, zeroed while their output is idle.
    always_comb begin
        out0_pld      = gate_pld(out0_vld, head0);
        out1_pld      = gate_pld(out1_vld, head1);

        out0_opcode   = out0_pld.opcode;
        out0_data     = out0_pld.data;
        out0_sideband = out0_pld.sideband;
        out0_src_id   = out0_pld.src_id;
        out0_tgt_id   = out0_pld.tgt_id;

        out1_opcode   = out1_pld.opcode;
        out1_data     = out1_pld.data;
        out1_sideband = out1_pld.sideband;
        out1_src_id   = out1_pld.src_id;
        out1_tgt_id   = out1_pld.tgt_id;
    end

    // Sticky error flag and saturating counter for discarded beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unroutable <= 1'b0;
            drop_cnt       <= '0;
        end else if (drop_acc) begin
            err_unroutable <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_toy_bus_ack_dec_node_2out.sv
// Randomized and directed bench for the ack split node against a queue-based model.
module tb_toy_bus_ack_dec_node_2out;
    import toy_bus_ack_pkg::*;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned DROP_CNT_W = 8;
    localparam int          DROP_MAX   = (1 << DROP_CNT_W) - 1;

    logic clk;
    logic rst_n;

    logic                    in0_vld, in0_rdy;
    logic [ACK_OPCODE_W-1:0] in0_opcode;
    logic [ACK_DATA_W-1:0]   in0_data;
    logic [ACK_SB_W-1:0]     in0_sideband;
    logic [ID_W-1:0]         in0_src_id, in0_tgt_id;

    logic                    out0_vld, out0_rdy;
    logic [ACK_OPCODE_W-1:0] out0_opcode;
    logic [ACK_DATA_W-1:0]   out0_data;
    logic [ACK_SB_W-1:0]     out0_sideband;
    logic [ID_W-1:0]         out0_src_id, out0_tgt_id;

    logic                    out1_vld, out1_rdy;
    logic [ACK_OPCODE_W-1:0] out1_opcode;
    logic [ACK_DATA_W-1:0]   out1_data;
    logic [ACK_SB_W-1:0]     out1_sideband;
    logic [ID_W-1:0]         out1_src_id, out1_tgt_id;

    logic                    err_unroutable;
    logic [DROP_CNT_W-1:0]   drop_cnt;

    toy_bus_ack_dec_node_2out #(
        .OUT0_TGT_ID (4'd0),
        .OUT1_TGT_ID (4'd1),
        .DEPTH       (DEPTH),
        .DROP_CNT_W  (DROP_CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in0_vld        (in0_vld),
        .in0_rdy        (in0_rdy),
        .in0_opcode     (in0_opcode),
        .in0_data       (in0_data),
        .in0_sideband   (in0_sideband),
        .in0_src_id     (in0_src_id),
        .in0_tgt_id     (in0_tgt_id),
        .out0_vld       (out0_vld),
        .out0_rdy       (out0_rdy),
        .out0_opcode    (out0_opcode),
        .out0_data      (out0_data),
        .out0_sideband  (out0_sideband),
        .out0_src_id    (out0_src_id),
        .out0_tgt_id    (out0_tgt_id),
        .out1_vld       (out1_vld),
        .out1_rdy       (out1_rdy),
        .out1_opcode    (out1_opcode),
        .out1_data      (out1_data),
        .out1_sideband  (out1_sideband),
        .out1_src_id    (out1_src_id),
        .out1_tgt_id    (out1_tgt_id),
        .err_unroutable (err_unroutable),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per target, plus drop bookkeeping.
    ack_pld_t q0[$];
    ack_pld_t q1[$];
    int       drop_m;
    bit       err_m;
    bit       stalled;
    ack_pld_t held_p;

    int n_chk;
    int n_pass;

    task automatic check(input string tag, input logic [ACK_PLD_W-1:0] obs, input logic [ACK_PLD_W-1:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic ack_pld_t rand_pld(input logic [ID_W-1:0] tgt);
        ack_pld_t p;
        p.opcode = ACK_OPCODE_W'($urandom_range(0, 1));
        for (int unsigned i = 0; i < ACK_DATA_W / 32; i++) begin
            p.data[i*32 +: 32] = $urandom();
        end
        p.sideband = $urandom();
        p.src_id   = ID_W'($urandom_range(0, 15));
        p.tgt_id   = tgt;
        return p;
    endfunction

    function automatic logic [ID_W-1:0] rand_tgt();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 4) return 4'd0;
        if (r < 8) return 4'd1;
        return ID_W'($urandom_range(2, 15));
    endfunction

    task automatic check_outputs();
        ack_pld_t e0;
        ack_pld_t e1;
        e0 = (q0.size() != 0) ? q0[0] : '0;
        e1 = (q1.size() != 0) ? q1[0] : '0;
        check("out0_vld", out0_vld, q0.size() != 0);
        check("out0_pld", {out0_opcode, out0_data, out0_sideband, out0_src_id, out0_tgt_id}, e0);
        check("out1_vld", out1_vld, q1.size() != 0);
        check("out1_pld", {out1_opcode, out1_data, out1_sideband, out1_src_id, out1_tgt_id}, e1);
        check("err_unroutable", err_unroutable, err_m);
        check("drop_cnt", drop_cnt, drop_m);
    endtask

    // One clock cycle: check registered outputs, apply inputs, check ready, advance model.
    task automatic cycle(input bit v, input ack_pld_t p, input bit r0, input bit r1);
        bit to0, to1, exp_rdy, pop0, pop1;
        @(negedge clk);
        check_outputs();
        in0_vld      = v;
        in0_opcode   = p.opcode;
        in0_data     = p.data;
        in0_sideband = p.sideband;
        in0_src_id   = p.src_id;
        in0_tgt_id   = p.tgt_id;
        out0_rdy     = r0;
        out1_rdy     = r1;
        #1;
        to0     = (p.tgt_id == 4'd0);
        to1     = (p.tgt_id == 4'd1);
        exp_rdy = (to0 && q0.size() < DEPTH) || (to1 && q1.size() < DEPTH) || (!to0 && !to1);
        check("in0_rdy", in0_rdy, exp_rdy);
        pop0    = (q0.size() != 0) && r0;
        pop1    = (q1.size() != 0) && r1;
        stalled = v && !exp_rdy;
        held_p  = p;
        @(posedge clk);
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (v && exp_rdy) begin
            if (to0) q0.push_back(p);
            else if (to1) q1.push_back(p);
            else begin
                err_m = 1'b1;
                if (drop_m < DROP_MAX) drop_m++;
            end
        end
    endtask

    task automatic idle(input bit r0, input bit r1);
        cycle(1'b0, '0, r0, r1);
    endtask

    initial begin
        ack_pld_t p;
        ack_pld_t pa, pb, pc;
        bit v;
        n_chk = 0;
        n_pass = 0;
        q0.delete();
        q1.delete();
        drop_m = 0;
        err_m = 1'b0;
        stalled = 1'b0;
        held_p = '0;
        in0_vld = 1'b0; in0_opcode = '0; in0_data = '0; in0_sideband = '0;
        in0_src_id = '0; in0_tgt_id = '0; out0_rdy = 1'b0; out1_rdy = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_in0_rdy", in0_rdy, 1'b1);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat to target 0 with a recognisable data pattern.
        p = rand_pld(4'd0);
        p.data = {8{32'hA5A5_A5A5}};
        cycle(1'b1, p, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Back-to-back alternating targets, both outputs ready.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, rand_pld(ID_W'(i % 2)), 1'b1, 1'b1);
        end
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Backpressure on out0; target-1 beat still flows.
        pa = rand_pld(4'd0); pb = rand_pld(4'd0); pc = rand_pld(4'd0);
        cycle(1'b1, pa, 1'b0, 1'b1);
        cycle(1'b1, pb, 1'b0, 1'b1);
        cycle(1'b1, pc, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        cycle(1'b1, rand_pld(4'd1), 1'b0, 1'b1);
        cycle(1'b1, pc, 1'b0, 1'b1);
        cycle(1'b1, pc, 1'b1, 1'b1);
        cycle(1'b1, pc, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);

        // Steady push+pop at count 1 so the pointers wrap repeatedly.
        cycle(1'b1, rand_pld(4'd0), 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, rand_pld(4'd0), 1'b1, 1'b1);
            check("cnt1_steady", out0_vld, 1'b1);
        end
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);

        // Unroutable target held long enough to saturate the counter.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, rand_pld(4'd7), 1'b1, 1'b1);
        end
        idle(1'b1, 1'b1);
        check("drop_sat", drop_cnt, DROP_MAX);
        check("err_sticky", err_unroutable, 1'b1);

        // Fill both FIFOs, then reset mid-cycle.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, rand_pld(ID_W'(i % 2)), 1'b0, 1'b0);
        end
        @(negedge clk);
        check("full_pre_rst0", out0_vld, 1'b1);
        check("full_pre_rst1", out1_vld, 1'b1);
        in0_vld = 1'b0;
        in0_tgt_id = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        drop_m = 0;
        err_m = 1'b0;
        stalled = 1'b0;
        check_outputs();
        check("rst_rdy", in0_rdy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, rand_pld(4'd1), 1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Randomized traffic with random backpressure and held stalls.
        for (int i = 0; i < 3000; i++) begin
            if (stalled) begin
                v = 1'b1;
                p = held_p;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                p = rand_pld(rand_tgt());
            end
            if (i < 1500) cycle(v, p, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            else cycle(v, p, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
        @(negedge clk);
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
